// File: rtl/wiz_pkg.sv
// Shared definitions for the CPLD-side W5300 bus blocks: FSM encoding, default timing, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wiz_pkg;

  // Bus-cycle phases; the encoding is shared with the other CPLD bus blocks.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } wiz_state_t;

  // Default W5300 timing in fclk cycles.
  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_STROBE_CYC   = 3;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_RECOVERY_CYC = 2;
  localparam int DEF_CNT_W        = 3;

  // One decoded access: direction, W5300 address and write data.
  typedef struct packed {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] wdata;
  } wiz_req_t;

endpackage

// File: rtl/wiz_bus_cycle_if.sv
// Request/response and W5300 pin bundle for the bus-cycle engine.
// Latency: n/a (wiring only).
// Backpressure: n/a; the engine exports busy/zwait_n/ovr for the requester.
interface wiz_bus_cycle_if;

  logic       req;
  logic       req_wr;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       ovr;
  logic       ovr_clr;
  logic       zwait_n;
  logic [9:0] w5300_addr;
  logic       w5300_cs_n;
  logic       w5300_rd_n;
  logic       w5300_wr_n;
  logic [7:0] w5300_dout;
  logic       w5300_doe;
  logic [7:0] w5300_din;

  // Requester side (address mapper plus the W5300 data input).
  modport master (
    output req, req_wr, req_addr, req_wdata, ovr_clr, w5300_din,
    input  busy, done, rd_data, ovr, zwait_n,
    input  w5300_addr, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_dout, w5300_doe
  );

  // Bus-cycle engine side.
  modport slave (
    input  req, req_wr, req_addr, req_wdata, ovr_clr, w5300_din,
    output busy, done, rd_data, ovr, zwait_n,
    output w5300_addr, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_dout, w5300_doe
  );

endinterface

// File: rtl/wiz_cyc_timer.sv
// Loadable down-counter timing each bus-cycle phase; tc flags the last cycle of a phase.
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; it stops at zero and holds there until reloaded.
module wiz_cyc_timer #(
  parameter int CNT_W = 3
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge fclk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == '0);

endmodule

// File: rtl/wiz_bus_cycle.sv
// Runs W5300 nCS/nRD/nWR bus cycles for Z80 window accesses with programmable phase timing.
// Latency: req edge to done = 1+SETUP_CYC+STROBE_CYC cycles; pins lag the FSM state by one register.
// Backpressure: zwait_n stalls the Z80; one pending slot, further reqs while full are dropped into ovr.
module wiz_bus_cycle
  import wiz_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            fclk,
  input  logic            rst,
  wiz_bus_cycle_if.slave  bus
);

  wiz_state_t       state_q, state_d;
  wiz_req_t         act_q, act_d;
  wiz_req_t         pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             zwait_n_q, zwait_n_d;
  logic [9:0]       addr_q, addr_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic [7:0]       dout_q, dout_d;
  logic             doe_q, doe_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_tc;
  logic             consume;
  wiz_req_t         new_req;
  logic             in_cyc;
  logic             hold_first;

  wiz_cyc_timer #(.CNT_W(CNT_W)) u_timer (
    .fclk     (fclk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .cnt      (tmr_cnt),
    .tc       (tmr_tc)
  );

  // Phase sequencing, pending-slot bookkeeping and sticky overflow.
  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    ovr_d        = ovr_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    consume      = 1'b0;
    new_req      = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};

    case (state_q)
      ST_IDLE: begin
        // A slot filled while RECOVER ended is served before any new req.
        if (pend_vld_q) begin
          act_d        = pend_q;
          consume      = 1'b1;
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(SETUP_CYC - 1);
        end else if (bus.req) begin
          act_d        = new_req;
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d      = ST_STROBE;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(STROBE_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (tmr_tc) begin
          state_d      = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          state_d      = ST_RECOVER;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(RECOVERY_CYC - 1);
        end
      end
      ST_RECOVER: begin
        if (tmr_tc) begin
          if (pend_vld_q) begin
            act_d        = pend_q;
            consume      = 1'b1;
            state_d      = ST_SETUP;
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (consume) begin
      pend_vld_d = 1'b0;
    end

    // Clear first so that a same-cycle drop wins.
    if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end

    // Any req that does not start a cycle directly goes to the slot or is dropped.
    if (bus.req && !(state_q == ST_IDLE && !pend_vld_q)) begin
      if (!pend_vld_q || consume) begin
        pend_vld_d = 1'b1;
        pend_d     = new_req;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Pin and status values for the next cycle, decoded from the current phase.
  always_comb begin
    in_cyc     = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    hold_first = (state_q == ST_HOLD) && (tmr_cnt == CNT_W'(HOLD_CYC - 1));

    busy_d    = (state_q != ST_IDLE) || pend_vld_q;
    done_d    = hold_first;
    zwait_n_d = !((state_q == ST_SETUP) || (state_q == ST_STROBE));
    cs_n_d    = !in_cyc;
    rd_n_d    = !((state_q == ST_STROBE) && !act_q.wr);
    wr_n_d    = !((state_q == ST_STROBE) && act_q.wr);
    doe_d     = in_cyc && act_q.wr;

    // The edge that ends the last strobe cycle is the one that sees the first HOLD phase.
    rd_data_d = rd_data_q;
    if (hold_first && !act_q.wr) begin
      rd_data_d = bus.w5300_din;
    end

    // Address and write data change only at SETUP so they stay stable through HOLD.
    addr_d = addr_q;
    dout_d = dout_q;
    if (state_q == ST_SETUP) begin
      addr_d = act_q.addr;
      if (act_q.wr) begin
        dout_d = act_q.wdata;
      end
    end
  end

  // All state and registered outputs; reset drops strobes at once, no partial cycle.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      zwait_n_q  <= 1'b1;
      addr_q     <= 10'h000;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      dout_q     <= 8'h00;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      zwait_n_q  <= zwait_n_d;
      addr_q     <= addr_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.ovr        = ovr_q;
  assign bus.zwait_n    = zwait_n_q;
  assign bus.w5300_addr = addr_q;
  assign bus.w5300_cs_n = cs_n_q;
  assign bus.w5300_rd_n = rd_n_q;
  assign bus.w5300_wr_n = wr_n_q;
  assign bus.w5300_dout = dout_q;
  assign bus.w5300_doe  = doe_q;

endmodule

// File: tb/tb_wiz_bus_cycle.sv
// Directed bench for wiz_bus_cycle: default timing instance plus a SETUP=2/STROBE=1/HOLD=2/RECOVERY=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_wiz_bus_cycle;

  logic fclk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   base = 1000000;
  int   sel = 0;
  int   idx;
  int   checks = 0;
  int   errors = 0;

  // Per-cycle history, bit k = value seen k cycles after the starting req edge.
  logic [31:0] h_cs, h_rd, h_wr, h_done, h_zw, h_busy, h_doe, h_ovr;
  logic [7:0]  h_rdd [32];

  wiz_bus_cycle_if ia();
  wiz_bus_cycle_if ib();

  wiz_bus_cycle u_a (
    .fclk (fclk),
    .rst  (rst),
    .bus  (ia)
  );

  wiz_bus_cycle #(
    .SETUP_CYC    (2),
    .STROBE_CYC   (1),
    .HOLD_CYC     (2),
    .RECOVERY_CYC (1),
    .CNT_W        (3)
  ) u_b (
    .fclk (fclk),
    .rst  (rst),
    .bus  (ib)
  );

  always #5 fclk = ~fclk;

  always @(posedge fclk) cyc <= cyc + 1;

  // Mid-cycle sampling of the selected instance into the history vectors.
  always @(negedge fclk) begin
    idx = cyc - base;
    if (idx >= 0 && idx < 32) begin
      if (sel == 0) begin
        h_cs[idx[4:0]]   = ia.w5300_cs_n;
        h_rd[idx[4:0]]   = ia.w5300_rd_n;
        h_wr[idx[4:0]]   = ia.w5300_wr_n;
        h_done[idx[4:0]] = ia.done;
        h_zw[idx[4:0]]   = ia.zwait_n;
        h_busy[idx[4:0]] = ia.busy;
        h_doe[idx[4:0]]  = ia.w5300_doe;
        h_ovr[idx[4:0]]  = ia.ovr;
        h_rdd[idx[4:0]]  = ia.rd_data;
      end else begin
        h_cs[idx[4:0]]   = ib.w5300_cs_n;
        h_rd[idx[4:0]]   = ib.w5300_rd_n;
        h_wr[idx[4:0]]   = ib.w5300_wr_n;
        h_done[idx[4:0]] = ib.done;
        h_zw[idx[4:0]]   = ib.zwait_n;
        h_busy[idx[4:0]] = ib.busy;
        h_doe[idx[4:0]]  = ib.w5300_doe;
        h_ovr[idx[4:0]]  = ib.ovr;
        h_rdd[idx[4:0]]  = ib.rd_data;
      end
    end
  end

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Called just after the req edge: that edge becomes k=0.
  task automatic clear_hist();
    base   = cyc;
    h_cs   = '1;
    h_rd   = '1;
    h_wr   = '1;
    h_done = '0;
    h_zw   = '1;
    h_busy = '0;
    h_doe  = '0;
    h_ovr  = '0;
    for (int i = 0; i < 32; i++) h_rdd[i] = 8'h00;
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [9:0] a, input logic [7:0] d);
    if (s == 0) begin
      ia.req = r; ia.req_wr = w; ia.req_addr = a; ia.req_wdata = d;
    end else begin
      ib.req = r; ib.req_wr = w; ib.req_addr = a; ib.req_wdata = d;
    end
  endtask

  task automatic test_reset();
    logic [33:0] exp_v;
    logic [33:0] got_a;
    logic [33:0] got_b;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_v = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 8'h00};
    got_a = {ia.busy, ia.done, ia.rd_data, ia.ovr, ia.zwait_n, ia.w5300_cs_n, ia.w5300_rd_n,
             ia.w5300_wr_n, ia.w5300_doe, ia.w5300_addr, ia.w5300_dout};
    got_b = {ib.busy, ib.done, ib.rd_data, ib.ovr, ib.zwait_n, ib.w5300_cs_n, ib.w5300_rd_n,
             ib.w5300_wr_n, ib.w5300_doe, ib.w5300_addr, ib.w5300_dout};
    checks++;
    if (got_a !== exp_v) begin errors++; $display("FAIL reset_a: got %h expected %h", got_a, exp_v); end
    checks++;
    if (got_b !== exp_v) begin errors++; $display("FAIL reset_b: got %h expected %h", got_b, exp_v); end
  endtask

  task automatic test_write();
    sel = 0;
    repeat (2) tick();
    drive(0, 1'b1, 1'b1, 10'h3FE, 8'hA5);
    tick();
    clear_hist();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (13) tick();
    checks++;
    if (h_cs[12:0] !== 13'h1FC1) begin errors++; $display("FAIL wr_cs_n: got %h expected %h", h_cs[12:0], 13'h1FC1); end
    checks++;
    if (h_wr[12:0] !== 13'h1FE3) begin errors++; $display("FAIL wr_wr_n: got %h expected %h", h_wr[12:0], 13'h1FE3); end
    checks++;
    if (h_rd[12:0] !== 13'h1FFF) begin errors++; $display("FAIL wr_rd_n: got %h expected %h", h_rd[12:0], 13'h1FFF); end
    checks++;
    if (h_done[12:0] !== 13'h0020) begin errors++; $display("FAIL wr_done: got %h expected %h", h_done[12:0], 13'h0020); end
    checks++;
    if (h_zw[12:0] !== 13'h1FE1) begin errors++; $display("FAIL wr_zwait_n: got %h expected %h", h_zw[12:0], 13'h1FE1); end
    checks++;
    if (h_busy[12:0] !== 13'h00FE) begin errors++; $display("FAIL wr_busy: got %h expected %h", h_busy[12:0], 13'h00FE); end
    checks++;
    if (h_doe[12:0] !== 13'h003E) begin errors++; $display("FAIL wr_doe: got %h expected %h", h_doe[12:0], 13'h003E); end
    checks++;
    if ({ia.w5300_addr, ia.w5300_dout} !== {10'h3FE, 8'hA5}) begin
      errors++; $display("FAIL wr_addr_dout: got %h/%h expected 3fe/a5", ia.w5300_addr, ia.w5300_dout);
    end
  endtask

  task automatic test_read();
    sel = 0;
    ia.w5300_din = 8'h5C;
    repeat (2) tick();
    drive(0, 1'b1, 1'b0, 10'h002, 8'h00);
    tick();
    clear_hist();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (7) tick();
    ia.w5300_din = 8'h00;
    repeat (6) tick();
    checks++;
    if (h_rd[12:0] !== 13'h1FE3) begin errors++; $display("FAIL rd_rd_n: got %h expected %h", h_rd[12:0], 13'h1FE3); end
    checks++;
    if (h_wr[12:0] !== 13'h1FFF) begin errors++; $display("FAIL rd_wr_n: got %h expected %h", h_wr[12:0], 13'h1FFF); end
    checks++;
    if (h_doe[12:0] !== 13'h0000) begin errors++; $display("FAIL rd_doe: got %h expected %h", h_doe[12:0], 13'h0000); end
    checks++;
    if (h_done[12:0] !== 13'h0020) begin errors++; $display("FAIL rd_done: got %h expected %h", h_done[12:0], 13'h0020); end
    checks++;
    if (h_rdd[4] !== 8'h00) begin errors++; $display("FAIL rd_data_early: got %h expected 00", h_rdd[4]); end
    checks++;
    if (h_rdd[5] !== 8'h5C) begin errors++; $display("FAIL rd_data_at_done: got %h expected 5c", h_rdd[5]); end
    checks++;
    if (ia.rd_data !== 8'h5C) begin errors++; $display("FAIL rd_data_held: got %h expected 5c", ia.rd_data); end
    checks++;
    if (ia.w5300_addr !== 10'h002) begin errors++; $display("FAIL rd_addr: got %h expected 002", ia.w5300_addr); end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    ia.w5300_din = 8'h33;
    repeat (2) tick();
    drive(0, 1'b1, 1'b1, 10'h0F0, 8'h42);
    tick();
    clear_hist();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (2) tick();
    drive(0, 1'b1, 1'b0, 10'h155, 8'h00);
    tick();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (17) tick();
    checks++;
    if (h_cs[18:0] !== 19'h7E0C1) begin errors++; $display("FAIL b2b_cs_n: got %h expected %h", h_cs[18:0], 19'h7E0C1); end
    checks++;
    if (h_done[18:0] !== 19'h01020) begin errors++; $display("FAIL b2b_done: got %h expected %h", h_done[18:0], 19'h01020); end
    checks++;
    if (h_rd[18:0] !== 19'h7F1FF) begin errors++; $display("FAIL b2b_rd_n: got %h expected %h", h_rd[18:0], 19'h7F1FF); end
    checks++;
    if (h_wr[18:0] !== 19'h7FFE3) begin errors++; $display("FAIL b2b_wr_n: got %h expected %h", h_wr[18:0], 19'h7FFE3); end
    checks++;
    if (h_zw[18:0] !== 19'h7F0E1) begin errors++; $display("FAIL b2b_zwait_n: got %h expected %h", h_zw[18:0], 19'h7F0E1); end
    checks++;
    if (h_busy[18:0] !== 19'h07FFE) begin errors++; $display("FAIL b2b_busy: got %h expected %h", h_busy[18:0], 19'h07FFE); end
    checks++;
    if ({ia.w5300_addr, ia.rd_data} !== {10'h155, 8'h33}) begin
      errors++; $display("FAIL b2b_addr_data: got %h/%h expected 155/33", ia.w5300_addr, ia.rd_data);
    end
  endtask

  task automatic test_overflow();
    sel = 0;
    ia.w5300_din = 8'h3C;
    repeat (2) tick();
    drive(0, 1'b1, 1'b1, 10'h0AA, 8'h11);
    tick();
    clear_hist();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    tick();
    drive(0, 1'b1, 1'b0, 10'h111, 8'h00);
    tick();
    drive(0, 1'b1, 1'b1, 10'h222, 8'h99);
    tick();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (19) tick();
    checks++;
    if (h_ovr[3:2] !== 2'b10) begin errors++; $display("FAIL ovr_set_edge: got %b expected 10", h_ovr[3:2]); end
    checks++;
    if (ia.ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ia.ovr); end
    checks++;
    if ($countones(h_done[21:0]) != 2) begin
      errors++; $display("FAIL ovr_done_count: got %0d expected 2", $countones(h_done[21:0]));
    end
    checks++;
    if (22 - $countones(h_cs[21:0]) != 10) begin
      errors++; $display("FAIL ovr_cs_low_count: got %0d expected 10", 22 - $countones(h_cs[21:0]));
    end
    checks++;
    if ({ia.w5300_addr, ia.rd_data} !== {10'h111, 8'h3C}) begin
      errors++; $display("FAIL ovr_served: got %h/%h expected 111/3c", ia.w5300_addr, ia.rd_data);
    end
    ia.ovr_clr = 1'b1;
    tick();
    ia.ovr_clr = 1'b0;
    checks++;
    if (ia.ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b expected 0", ia.ovr); end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    repeat (2) tick();
    drive(0, 1'b1, 1'b1, 10'h3C3, 8'h5A);
    tick();
    clear_hist();
    drive(0, 1'b1, 1'b1, 10'h001, 8'h01);
    tick();
    drive(0, 1'b1, 1'b1, 10'h002, 8'h02);
    tick();
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    tick();
    checks++;
    if ({ia.w5300_wr_n, ia.ovr, ia.busy} !== 3'b011) begin
      errors++; $display("FAIL rstmid_before: got %b expected 011", {ia.w5300_wr_n, ia.ovr, ia.busy});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ia.w5300_wr_n, ia.w5300_cs_n, ia.w5300_doe, ia.zwait_n, ia.busy, ia.ovr, ia.done} !== 7'b1101000) begin
      errors++; $display("FAIL rstmid_pins: got %b expected 1101000",
                         {ia.w5300_wr_n, ia.w5300_cs_n, ia.w5300_doe, ia.zwait_n, ia.busy, ia.ovr, ia.done});
    end
    checks++;
    if (ia.rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd_data: got %h expected 00", ia.rd_data); end
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (h_cs[14:4] !== 11'h7FF) begin errors++; $display("FAIL rstmid_no_pending: got %h expected 7ff", h_cs[14:4]); end
    checks++;
    if (h_busy[14:4] !== 11'h000) begin errors++; $display("FAIL rstmid_busy: got %h expected 000", h_busy[14:4]); end
  endtask

  task automatic test_params();
    sel = 1;
    ib.w5300_din = 8'h77;
    repeat (2) tick();
    drive(1, 1'b1, 1'b1, 10'h100, 8'h0F);
    tick();
    clear_hist();
    drive(1, 1'b1, 1'b0, 10'h201, 8'h00);
    tick();
    drive(1, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (16) tick();
    checks++;
    if (h_cs[15:0] !== 16'hF041) begin errors++; $display("FAIL par_cs_n: got %h expected f041", h_cs[15:0]); end
    checks++;
    if (h_done[15:0] !== 16'h0410) begin errors++; $display("FAIL par_done: got %h expected 0410", h_done[15:0]); end
    checks++;
    if (h_wr[15:0] !== 16'hFFF7) begin errors++; $display("FAIL par_wr_n: got %h expected fff7", h_wr[15:0]); end
    checks++;
    if (h_rd[15:0] !== 16'hFDFF) begin errors++; $display("FAIL par_rd_n: got %h expected fdff", h_rd[15:0]); end
    checks++;
    if (h_busy[15:0] !== 16'h1FFE) begin errors++; $display("FAIL par_busy: got %h expected 1ffe", h_busy[15:0]); end
    checks++;
    if ({ib.w5300_addr, ib.rd_data} !== {10'h201, 8'h77}) begin
      errors++; $display("FAIL par_addr_data: got %h/%h expected 201/77", ib.w5300_addr, ib.rd_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 10'h000, 8'h00);
    drive(1, 1'b0, 1'b0, 10'h000, 8'h00);
    ia.ovr_clr = 1'b0;
    ib.ovr_clr = 1'b0;
    ia.w5300_din = 8'h00;
    ib.w5300_din = 8'h00;
    clear_hist();
    base = 1000000;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
